// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
//
// Bundles the three buses that meet at the unified memory arbiter:
//   - instruction-fetch port (i_*): read-only requester
//   - data port (d_*): read/write requester
//   - RAM port (mem_*): single-ported synchronous RAM, 1-cycle read latency
//
// Modports:
//   slave  : the arbiter's view (takes requests, drives grants/responses,
//            drives the RAM command, receives RAM read data)
//   master : the environment's view (CPU ports plus the RAM itself)
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    // Data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // RAM port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported synchronous RAM between the CPU instruction-fetch
// port (I) and the data port (D) so that code and data live in one memory
// image. Data accesses win conflicts so loads/stores can retire; a starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive fetch losses.
//
// Ports:
//   clk          : system clock, all state updates on the rising edge
//   rst_n        : synchronous active-low reset
//   bus          : unified_mem_arbiter_if.slave
//                    i_req/i_addr -> i_gnt, i_rvalid, i_rdata
//                    d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata
//                    mem_en/mem_we/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM
//   conflict_cnt : saturating count of cycles with i_req & d_req both high
//
// Parameters:
//   ADDR_W       : address width (byte address passed through unchanged)
//   DATA_W       : data width
//   STARVE_LIMIT : fetch losses tolerated before fetch is forced (1..15)
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    unified_mem_arbiter_if.slave   bus,
    output logic [15:0]            conflict_cnt
);

    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    // ------------------------------------------------------------------
    // Local copies of the request side
    // ------------------------------------------------------------------
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;

    assign i_req   = bus.i_req;
    assign i_addr  = bus.i_addr;
    assign d_req   = bus.d_req;
    assign d_we    = bus.d_we;
    assign d_addr  = bus.d_addr;
    assign d_wdata = bus.d_wdata;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        resp_i_reg;
    logic        resp_d_reg;
    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    logic [15:0] conflict_cnt_reg;
    logic [15:0] conflict_cnt_next;

    // ------------------------------------------------------------------
    // Grant decision (combinational, same cycle as the request)
    // ------------------------------------------------------------------
    logic conflict;
    logic starved;
    logic i_gnt;
    logic d_gnt;

    assign conflict = i_req & d_req;
    assign starved  = (starve_cnt_reg == STARVE_MAX);

    // Grants are gated by rst_n so no access can start while reset is held.
    // On a conflict D wins unless fetch has already lost STARVE_LIMIT times.
    assign i_gnt = rst_n & i_req & (~d_req | starved);
    assign d_gnt = rst_n & d_req & ~(i_req & starved);

    assign bus.i_gnt = i_gnt;
    assign bus.d_gnt = d_gnt;

    // ------------------------------------------------------------------
    // RAM command mux
    // Grants are one-hot (or zero), so an AND-OR mux selects the granted
    // port and naturally yields all-zero address/data with no grant.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_mux
            assign mem_addr[gi] = (i_gnt & i_addr[gi]) | (d_gnt & d_addr[gi]);
        end
        // Fetch never writes, so write data only ever comes from D.
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_wdata_mux
            assign mem_wdata[gi] = d_gnt & d_wdata[gi];
        end
    endgenerate

    assign bus.mem_en    = i_gnt | d_gnt;
    assign bus.mem_we    = d_gnt & d_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    // ------------------------------------------------------------------
    // Read response routing
    // The RAM returns data one cycle after the access, so the owner of the
    // response is simply whoever was granted a read in the previous cycle.
    // Writes produce no response.
    // ------------------------------------------------------------------
    assign bus.i_rvalid = resp_i_reg;
    assign bus.d_rvalid = resp_d_reg;
    assign bus.i_rdata  = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        // Any fetch grant, or fetch no longer asking, ends the losing streak.
        if (i_gnt || !i_req) begin
            starve_cnt_next = 4'd0;
        end else if (d_gnt && (starve_cnt_reg < STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        conflict_cnt_next = conflict_cnt_reg;
        if (conflict && (conflict_cnt_reg != CNT_MAX)) begin
            conflict_cnt_next = conflict_cnt_reg + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_i_reg       <= 1'b0;
            resp_d_reg       <= 1'b0;
            starve_cnt_reg   <= 4'd0;
            conflict_cnt_reg <= 16'd0;
        end else begin
            resp_i_reg       <= i_gnt;
            resp_d_reg       <= d_gnt & ~d_we;
            starve_cnt_reg   <= starve_cnt_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed bench for unified_mem_arbiter with a small behavioural RAM
// (1-cycle registered read). Inputs are driven 1 ns after the rising edge,
// combinational outputs are checked 1 ns later, registered outputs are
// checked in the cycle that follows their launching edge.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    unified_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 256 words, word-addressed by byte address bits [9:2]
    logic [DATA_W-1:0] ram [0:255];
    logic [DATA_W-1:0] ram_q;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            ram_q <= ram[bus.mem_addr[9:2]];
        end
    end
    assign bus.mem_rdata = ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s observed=%0h", tag, obs);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    logic [9:0] exp_i_seq;
    logic [4:0] exp_i_seq2;

    initial begin
        for (int k = 0; k < 256; k++) ram[k] = '0;
        ram[8'h04] = 32'hDEADBEEF;   // byte 0x10
        ram[8'h0C] = 32'hCAFEF00D;   // byte 0x30
        ram[8'h10] = 32'h0BADF00D;   // byte 0x40
        ram_q = '0;

        // ---------------- Reset with both requests pending ----------------
        rst_n = 1'b0;
        idle();
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_addr = 32'h20;
        #2;
        check("rst_i_gnt",    bus.i_gnt,    1'b0);
        check("rst_d_gnt",    bus.d_gnt,    1'b0);
        check("rst_mem_en",   bus.mem_en,   1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        next_cycle();
        next_cycle();
        check("rst_i_rvalid", bus.i_rvalid, 1'b0);
        check("rst_d_rvalid", bus.d_rvalid, 1'b0);
        check("rst_conflict", conflict_cnt, 16'd0);
        idle();
        rst_n = 1'b1;

        // ---------------- Test 1: fetch read of 0x10 ----------------
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        #1;
        check("t1_i_gnt",    bus.i_gnt,    1'b1);
        check("t1_d_gnt",    bus.d_gnt,    1'b0);
        check("t1_mem_en",   bus.mem_en,   1'b1);
        check("t1_mem_we",   bus.mem_we,   1'b0);
        check("t1_mem_addr", bus.mem_addr, 32'h10);
        next_cycle();
        idle();
        #1;
        check("t1_i_rvalid",    bus.i_rvalid, 1'b1);
        check("t1_i_rdata",     bus.i_rdata,  32'hDEADBEEF);
        check("t1_d_rvalid",    bus.d_rvalid, 1'b0);
        check("t1_mem_en_idle", bus.mem_en,   1'b0);
        next_cycle();
        check("t1_i_rvalid_off", bus.i_rvalid, 1'b0);

        // ---------------- Test 2: data write then read of 0x20 ----------------
        bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
        #1;
        check("t2_wr_d_gnt",     bus.d_gnt,     1'b1);
        check("t2_wr_mem_we",    bus.mem_we,    1'b1);
        check("t2_wr_mem_addr",  bus.mem_addr,  32'h20);
        check("t2_wr_mem_wdata", bus.mem_wdata, 32'h12345678);
        next_cycle();
        bus.d_we = 1'b0; bus.d_wdata = '0;
        #1;
        check("t2_wr_no_rvalid", bus.d_rvalid, 1'b0);
        check("t2_rd_d_gnt",     bus.d_gnt,    1'b1);
        check("t2_rd_mem_we",    bus.mem_we,   1'b0);
        next_cycle();
        idle();
        #1;
        check("t2_rd_d_rvalid", bus.d_rvalid, 1'b1);
        check("t2_rd_d_rdata",  bus.d_rdata,  32'h12345678);
        check("t2_rd_i_rvalid", bus.i_rvalid, 1'b0);
        check("t2_conflict",    conflict_cnt, 16'd0);

        // ---------------- Test 3: 10 cycles of conflict ----------------
        // Expected grant sequence D,D,D,D,I,D,D,D,D,I (bit k = 1 means I)
        exp_i_seq = 10'b10_0001_0000;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            bus.i_req = 1'b1; bus.i_addr = 32'h10;
            bus.d_req = 1'b1; bus.d_addr = 32'h20;
            #1;
            check($sformatf("t3_i_gnt[%0d]", k), bus.i_gnt, exp_i_seq[k]);
            check($sformatf("t3_d_gnt[%0d]", k), bus.d_gnt, !exp_i_seq[k]);
        end
        next_cycle();
        idle();
        #1;
        check("t3_conflict_cnt", conflict_cnt, 16'd10);

        // ---------------- Test 4: fetch drops out after 3 losses ----------------
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.i_req = 1'b1; bus.d_req = 1'b1;
            #1;
            check($sformatf("t4_pre_d_gnt[%0d]", k), bus.d_gnt, 1'b1);
        end
        next_cycle();
        bus.i_req = 1'b0; bus.d_req = 1'b1;
        #1;
        check("t4_drop_d_gnt", bus.d_gnt, 1'b1);
        // Streak was cleared, so four D wins before I is forced on the fifth.
        exp_i_seq2 = 5'b1_0000;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            bus.i_req = 1'b1; bus.d_req = 1'b1;
            #1;
            check($sformatf("t4_i_gnt[%0d]", k), bus.i_gnt, exp_i_seq2[k]);
            check($sformatf("t4_d_gnt[%0d]", k), bus.d_gnt, !exp_i_seq2[k]);
        end
        next_cycle();
        idle();
        #1;
        check("t4_conflict_cnt", conflict_cnt, 16'd18);
        next_cycle();

        // ---------------- Test 5: I read then D read back to back ----------------
        bus.i_req = 1'b1; bus.i_addr = 32'h30;
        #1;
        check("t5_i_gnt", bus.i_gnt, 1'b1);
        next_cycle();
        idle();
        bus.d_req = 1'b1; bus.d_addr = 32'h40;
        #1;
        check("t5_d_gnt",       bus.d_gnt,    1'b1);
        check("t5_c1_i_rvalid", bus.i_rvalid, 1'b1);
        check("t5_c1_d_rvalid", bus.d_rvalid, 1'b0);
        check("t5_c1_i_rdata",  bus.i_rdata,  32'hCAFEF00D);
        next_cycle();
        idle();
        #1;
        check("t5_c2_i_rvalid", bus.i_rvalid, 1'b0);
        check("t5_c2_d_rvalid", bus.d_rvalid, 1'b1);
        check("t5_c2_d_rdata",  bus.d_rdata,  32'h0BADF00D);
        next_cycle();
        check("t5_c3_i_rvalid", bus.i_rvalid, 1'b0);
        check("t5_c3_d_rvalid", bus.d_rvalid, 1'b0);

        // ---------------- Test 6: reset right after an I grant ----------------
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        #1;
        check("t6_i_gnt", bus.i_gnt, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h20;
        #1;
        check("t6_rst_i_rvalid", bus.i_rvalid, 1'b1);
        check("t6_rst_i_rdata",  bus.i_rdata,  32'hDEADBEEF);
        check("t6_rst_i_gnt",    bus.i_gnt,    1'b0);
        check("t6_rst_d_gnt",    bus.d_gnt,    1'b0);
        check("t6_rst_mem_en",   bus.mem_en,   1'b0);
        check("t6_rst_mem_addr", bus.mem_addr, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        idle();
        #1;
        check("t6_post_i_rvalid", bus.i_rvalid, 1'b0);
        check("t6_post_d_rvalid", bus.d_rvalid, 1'b0);
        check("t6_post_i_gnt",    bus.i_gnt,    1'b0);
        check("t6_post_d_gnt",    bus.d_gnt,    1'b0);
        check("t6_post_conflict", conflict_cnt, 16'd0);

        // Starvation streak also cleared by reset: next conflict goes to D.
        next_cycle();
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        #1;
        check("t6_after_d_gnt", bus.d_gnt, 1'b1);
        next_cycle();
        idle();
        #1;
        check("t6_after_conflict", conflict_cnt, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
